// File: rtl/fp_sum_seq.sv
// fp_sum_seq: initiator-side controller that accumulates a vector of LEN
// single-precision elements through an external stb/ack float adder.
// The running sum goes to operand a and the next element to operand b.
// Each result z becomes the new running sum. The final total is handed downstream.
// Optional feature macro: FP_SUM_MAX_EN. When it is defined, the block tracks
// the largest non-NaN element on max_out. When it is not defined, max_out is
// tied to zero.
module fp_sum_seq #(
  parameter int unsigned LEN_W = 5,
  parameter logic [31:0] ZERO  = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic [31:0]      in_data,
  input  logic             in_stb,
  output logic             in_ack,
  output logic [31:0]      add_a,
  output logic [31:0]      add_b,
  output logic             add_a_stb,
  output logic             add_b_stb,
  input  logic             add_a_ack,
  input  logic             add_b_ack,
  input  logic [31:0]      add_z,
  input  logic             add_z_stb,
  output logic             add_z_ack,
  output logic [31:0]      sum,
  output logic             sum_stb,
  input  logic             sum_ack,
  output logic             busy,
  output logic [31:0]      max_out
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GET,
    S_SEND,
    S_WAIT_Z,
    S_PUT
  } state_t;

  state_t           state_q, state_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [31:0]      acc_q, acc_d;
  logic             in_ack_q, in_ack_d;
  logic [31:0]      add_a_q, add_a_d;
  logic [31:0]      add_b_q, add_b_d;
  logic             add_a_stb_q, add_a_stb_d;
  logic             add_b_stb_q, add_b_stb_d;
  logic             add_z_ack_q, add_z_ack_d;
  logic [31:0]      sum_q, sum_d;
  logic             sum_stb_q, sum_stb_d;
  logic             busy_q, busy_d;
  logic             a_done, b_done;
  logic             in_xfer;

  // Each operand channel counts as done once its strobe is already low or is taken this edge.
  always_comb begin
    a_done  = !add_a_stb_q || add_a_ack;
    b_done  = !add_b_stb_q || add_b_ack;
    in_xfer = in_stb && in_ack_q;
  end

  // Next-state and next-output logic for the accumulation sequence.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    in_ack_d    = in_ack_q;
    add_a_d     = add_a_q;
    add_b_d     = add_b_q;
    add_a_stb_d = add_a_stb_q;
    add_b_stb_d = add_b_stb_q;
    add_z_ack_d = add_z_ack_q;
    sum_d       = sum_q;
    sum_stb_d   = sum_stb_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (len != '0) begin
            acc_d    = ZERO;
            cnt_d    = len;
            in_ack_d = 1'b1;
            state_d  = S_GET;
          end else begin
            sum_d     = ZERO;
            sum_stb_d = 1'b1;
            state_d   = S_PUT;
          end
        end
      end
      S_GET: begin
        if (in_xfer) begin
          in_ack_d    = 1'b0;
          add_a_d     = acc_q;
          add_b_d     = in_data;
          add_a_stb_d = 1'b1;
          add_b_stb_d = 1'b1;
          state_d     = S_SEND;
        end
      end
      S_SEND: begin
        if (add_a_stb_q && add_a_ack) add_a_stb_d = 1'b0;
        if (add_b_stb_q && add_b_ack) add_b_stb_d = 1'b0;
        if (a_done && b_done) begin
          add_z_ack_d = 1'b1;
          state_d     = S_WAIT_Z;
        end
      end
      S_WAIT_Z: begin
        if (add_z_stb && add_z_ack_q) begin
          add_z_ack_d = 1'b0;
          acc_d       = add_z;
          cnt_d       = cnt_q - LEN_W'(1);
          if (cnt_q == LEN_W'(1)) begin
            sum_d     = add_z;
            sum_stb_d = 1'b1;
            state_d   = S_PUT;
          end else begin
            in_ack_d = 1'b1;
            state_d  = S_GET;
          end
        end
      end
      S_PUT: begin
        if (sum_stb_q && sum_ack) begin
          sum_stb_d = 1'b0;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and registered-output flops with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      in_ack_q    <= 1'b0;
      add_a_q     <= '0;
      add_b_q     <= '0;
      add_a_stb_q <= 1'b0;
      add_b_stb_q <= 1'b0;
      add_z_ack_q <= 1'b0;
      sum_q       <= '0;
      sum_stb_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      in_ack_q    <= in_ack_d;
      add_a_q     <= add_a_d;
      add_b_q     <= add_b_d;
      add_a_stb_q <= add_a_stb_d;
      add_b_stb_q <= add_b_stb_d;
      add_z_ack_q <= add_z_ack_d;
      sum_q       <= sum_d;
      sum_stb_q   <= sum_stb_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ack    = in_ack_q;
  assign add_a     = add_a_q;
  assign add_b     = add_b_q;
  assign add_a_stb = add_a_stb_q;
  assign add_b_stb = add_b_stb_q;
  assign add_z_ack = add_z_ack_q;
  assign sum       = sum_q;
  assign sum_stb   = sum_stb_q;
  assign busy      = busy_q;

`ifdef FP_SUM_MAX_EN
  logic [31:0] max_q, max_d;
  logic        have_max_q, have_max_d;

  function automatic logic is_nan(input logic [31:0] x);
    return (x[30:23] == 8'hff) && (x[22:0] != '0);
  endfunction

  // IEEE ordering on sign-magnitude; both zeros compare equal so the first one seen stays.
  function automatic logic fp_gt(input logic [31:0] x, input logic [31:0] y);
    logic r;
    if (x[30:0] == '0 && y[30:0] == '0) r = 1'b0;
    else if (x[31] != y[31])            r = y[31];
    else if (!x[31])                    r = x[30:0] > y[30:0];
    else                                r = x[30:0] < y[30:0];
    return r;
  endfunction

  // Clear on start, seed from the first non-NaN element, then keep the larger.
  always_comb begin
    max_d      = max_q;
    have_max_d = have_max_q;
    if (state_q == S_IDLE && start) begin
      max_d      = '0;
      have_max_d = 1'b0;
    end else if (state_q == S_GET && in_xfer && !is_nan(in_data) &&
                 (!have_max_q || fp_gt(in_data, max_q))) begin
      max_d      = in_data;
      have_max_d = 1'b1;
    end
  end

  // Max tracking flops.
  always_ff @(posedge clk) begin
    if (!rst) begin
      max_q      <= '0;
      have_max_q <= 1'b0;
    end else begin
      max_q      <= max_d;
      have_max_q <= have_max_d;
    end
  end

  assign max_out = max_q;
`else
  assign max_out = '0;
`endif

endmodule
